square_plotter: RTL and testbench

- Consumer end of the square-drawing interface. Accepts one request per square: a start strobe with a starting x/y corner and a colour.
- Rasterises the square into per-pixel writes (x, y, colour, writeEn) for the VGA adapter, in row-major order, one pixel per clock.
- Reports busy/done so the upstream square-sequencing FSM can pace its requests.

---
 rtl/square_plotter.sv | 135 +++++++++++++
 tb/tb_square_plotter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/square_plotter.sv
// Rasterises one SIZE x SIZE square per start request into row-major pixel writes.
// The registered outputs always show the pixel slot that belongs to the current state.
module square_plotter #(
    parameter int SIZE     = 4,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] starting_x,
    input  logic [6:0] starting_y,
    input  logic [2:0] colour_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       writeEn
);

    localparam int CW = $clog2(SIZE);
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    typedef enum logic [1:0] {IDLE, DRAW, FINISH} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cx, cx_nx, cy, cy_nx;
    logic [7:0]    base_x, base_x_nx;
    logic [6:0]    base_y, base_y_nx;
    logic [2:0]    col_lat, col_lat_nx;
    logic [7:0]    x_nx;
    logic [6:0]    y_nx;
    logic [2:0]    colour_nx;
    logic          we_nx, busy_nx, done_nx;
    logic          load;
    logic [8:0]    sum_x;
    logic [7:0]    sum_y;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cx      <= '0;
            cy      <= '0;
            base_x  <= '0;
            base_y  <= '0;
            col_lat <= '0;
            x       <= '0;
            y       <= '0;
            colour  <= '0;
            writeEn <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            cx      <= cx_nx;
            cy      <= cy_nx;
            base_x  <= base_x_nx;
            base_y  <= base_y_nx;
            col_lat <= col_lat_nx;
            x       <= x_nx;
            y       <= y_nx;
            colour  <= colour_nx;
            writeEn <= we_nx;
            busy    <= busy_nx;
            done    <= done_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cx_nx      = cx;
        cy_nx      = cy;
        base_x_nx  = base_x;
        base_y_nx  = base_y;
        col_lat_nx = col_lat;
        x_nx       = x;
        y_nx       = y;
        colour_nx  = colour;
        we_nx      = 1'b0;
        busy_nx    = 1'b0;
        done_nx    = 1'b0;
        load       = 1'b0;
        sum_x      = '0;
        sum_y      = '0;

        case (state)
            IDLE: begin
                if (start) load = 1'b1;
            end
            DRAW: begin
                if (cx == LAST && cy == LAST) begin
                    state_nx = FINISH;
                    done_nx  = 1'b1;
                end else begin
                    if (cx == LAST) begin
                        cx_nx = '0;
                        cy_nx = cy + CW'(1);
                    end else begin
                        cx_nx = cx + CW'(1);
                    end
                    busy_nx = 1'b1;
                    // Sums are one bit wider so wrapped coordinates are never written.
                    sum_x     = {1'b0, base_x} + 9'(cx_nx);
                    sum_y     = {1'b0, base_y} + 8'(cy_nx);
                    x_nx      = sum_x[7:0];
                    y_nx      = sum_y[6:0];
                    colour_nx = col_lat;
                    we_nx     = (sum_x < 9'(SCREEN_W)) && (sum_y < 8'(SCREEN_H));
                end
            end
            FINISH: begin
                if (start) load = 1'b1;
                else       state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        // Accepting a request presents slot (0,0) on the same edge.
        if (load) begin
            state_nx   = DRAW;
            base_x_nx  = starting_x;
            base_y_nx  = starting_y;
            col_lat_nx = colour_in;
            cx_nx      = '0;
            cy_nx      = '0;
            busy_nx    = 1'b1;
            x_nx       = starting_x;
            y_nx       = starting_y;
            colour_nx  = colour_in;
            we_nx      = (9'(starting_x) < 9'(SCREEN_W)) && (8'(starting_y) < 8'(SCREEN_H));
        end
    end

endmodule

// File: tb/tb_square_plotter.sv
// Self-checking bench for square_plotter: directed table, corner sequences and random squares
// compared against an arithmetic model of the pixel stream.
module tb_square_plotter;

    localparam int SIZE = 4;
    localparam int NPIX = SIZE * SIZE;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] starting_x;
    logic [6:0] starting_y;
    logic [2:0] colour_in;
    logic       busy, done, writeEn;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;

    int vectors = 0;
    int miscompares = 0;

    square_plotter #(.SIZE(SIZE), .SCREEN_W(160), .SCREEN_H(120)) dut (
        .clk(clk), .reset(reset), .start(start),
        .starting_x(starting_x), .starting_y(starting_y), .colour_in(colour_in),
        .busy(busy), .done(done), .x(x), .y(y), .colour(colour), .writeEn(writeEn)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] sx;
        logic [6:0] sy;
        logic [2:0] col;
        int         exp_writes;
    } req_t;

    req_t tbl[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Slot k of a square at (sx,sy): row-major position, unwrapped visibility test, wrapped display.
    task automatic check_slot(input logic [7:0] sx, input logic [6:0] sy, input logic [2:0] col,
                              input int k, inout int writes);
        int ux, uy;
        logic vis;
        ux  = int'(sx) + (k % SIZE);
        uy  = int'(sy) + (k / SIZE);
        vis = (ux < 160) && (uy < 120);
        chk($sformatf("slot%0d_x", k), 32'(x), 32'(ux % 256));
        chk($sformatf("slot%0d_y", k), 32'(y), 32'(uy % 128));
        chk($sformatf("slot%0d_col", k), 32'(colour), 32'(col));
        chk($sformatf("slot%0d_we", k), 32'(writeEn), 32'(vis));
        chk($sformatf("slot%0d_busy", k), 32'(busy), 32'd1);
        chk($sformatf("slot%0d_done", k), 32'(done), 32'd0);
        if (writeEn) writes++;
    endtask

    task automatic check_done(input logic [7:0] sx, input logic [6:0] sy);
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_we", 32'(writeEn), 32'd0);
        chk("done_hold_x", 32'(x), 32'((int'(sx) + SIZE - 1) % 256));
        chk("done_hold_y", 32'(y), 32'((int'(sy) + SIZE - 1) % 128));
    endtask

    // Full square; optionally pulses start with other coordinates at slot 5 to show it is ignored.
    task automatic run_square(input logic [7:0] sx, input logic [6:0] sy, input logic [2:0] col,
                              input int exp_writes, input bit poke);
        int writes = 0;
        @(negedge clk);
        start = 1'b1; starting_x = sx; starting_y = sy; colour_in = col;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < NPIX; k++) begin
            check_slot(sx, sy, col, k, writes);
            starting_x = 8'($urandom); starting_y = 7'($urandom); colour_in = 3'($urandom);
            start = poke && (k == 4);
            @(negedge clk);
        end
        start = 1'b0;
        check_done(sx, sy);
        if (exp_writes >= 0) chk("write_count", 32'(writes), 32'(exp_writes));
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
    endtask

    initial begin
        int writes;
        tbl[0] = '{sx: 8'd10,  sy: 7'd112, col: 3'b100, exp_writes: 16};
        tbl[1] = '{sx: 8'd158, sy: 7'd118, col: 3'b110, exp_writes: 4};
        tbl[2] = '{sx: 8'd254, sy: 7'd126, col: 3'b011, exp_writes: 0};
        tbl[3] = '{sx: 8'd157, sy: 7'd50,  col: 3'b000, exp_writes: 12};

        start = 1'b0; starting_x = '0; starting_y = '0; colour_in = '0;
        reset = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_we", 32'(writeEn), 32'd0);
        chk("rst_xyc", 32'({x, y, colour}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 4; i++)
            run_square(tbl[i].sx, tbl[i].sy, tbl[i].col, tbl[i].exp_writes, 1'b0);

        // start pulsed mid-square is dropped
        run_square(8'd40, 7'd20, 3'b101, 16, 1'b1);

        // start held high: second square follows done directly, 17 cycles apart
        writes = 0;
        @(negedge clk);
        start = 1'b1; starting_x = 8'd20; starting_y = 7'd112; colour_in = 3'b010;
        @(negedge clk);
        check_slot(8'd20, 7'd112, 3'b010, 0, writes);
        starting_x = 8'd30; colour_in = 3'b001;
        for (int k = 1; k < NPIX; k++) begin
            @(negedge clk);
            check_slot(8'd20, 7'd112, 3'b010, k, writes);
        end
        @(negedge clk);
        check_done(8'd20, 7'd112);
        @(negedge clk);
        start = 1'b0;
        check_slot(8'd30, 7'd112, 3'b001, 0, writes);
        for (int k = 1; k < NPIX; k++) begin
            @(negedge clk);
            check_slot(8'd30, 7'd112, 3'b001, k, writes);
        end
        @(negedge clk);
        check_done(8'd30, 7'd112);
        chk("b2b_writes", 32'(writes), 32'd32);

        // asynchronous reset during slot 7 abandons the square
        writes = 0;
        @(negedge clk);
        start = 1'b1; starting_x = 8'd10; starting_y = 7'd20; colour_in = 3'b111;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check_slot(8'd10, 7'd20, 3'b111, k, writes);
            if (k < 7) @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_we", 32'(writeEn), 32'd0);
        chk("arst_xyc", 32'({x, y, colour}), 32'd0);
        #4 reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("post_rst_quiet", 32'({busy, done, writeEn}), 32'd0);
        end
        run_square(8'd10, 7'd20, 3'b111, 16, 1'b0);

        for (int i = 0; i < 20; i++)
            run_square(8'($urandom), 7'($urandom), 3'($urandom), -1, 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
